// File: rtl/pio_pkg.sv
// Constants and helpers shared by the PIO FIFO and the state-machine wrapper.
package pio_pkg;

  localparam int FIFO_DEPTH_JOINED = 8;
  localparam int FIFO_DEPTH_SPLIT  = 4;
  localparam int LEVEL_W           = 4;

  // Pointer increment that wraps at the currently usable depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pio_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous (zero-latency) read.
module pio_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pio_fifo.sv
// PIO FIFO: first-word-fall-through queue whose usable depth is halved unless
// join_en is set; keeps pointers, level and sticky error flags around pio_fifo_mem.
module pio_fifo
  import pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = FIFO_DEPTH_JOINED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               join_en,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pull,
  input  logic               pull_en,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               underflow,
  input  logic               flag_clr
);

  localparam int PTR_W = $clog2(MAX_DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               join_q, join_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic [LEVEL_W-1:0] depth;
  logic               wr, rd, flush;
  logic [WIDTH-1:0]   rd_data;

  // Status depends only on registered state, never on this cycle's push/pull.
  assign depth     = join_q ? LEVEL_W'(MAX_DEPTH) : LEVEL_W'(MAX_DEPTH / 2);
  assign empty     = (level_q == '0);
  assign full      = (level_q == depth);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign dout      = empty ? '0 : rd_data;

  always_comb begin
    rd          = pull & pull_en & ~empty;
    wr          = push & (~full | rd);
    flush       = clear | (join_en != join_q);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    join_d      = join_en;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // A change of join_en flushes because the pointers wrap at the old depth.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(depth)));
      if (rd) rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(depth)));
      if (wr && !rd)      level_d = level_q + LEVEL_W'(1);
      else if (rd && !wr) level_d = level_q - LEVEL_W'(1);
    end

    if (flag_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push & ~wr)             overflow_d  = 1'b1;
      if (pull & pull_en & empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      join_q      <= join_d;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      join_q      <= join_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pio_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(MAX_DEPTH),
    .AW   (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr & ~flush & ~reset),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_pio_fifo.sv
// Scoreboard bench for pio_fifo: a queue-based reference model predicts every
// accepted read and status output; a negedge monitor compares the DUT against it.
module tb_pio_fifo;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, join_en, push, pull, pull_en, flag_clr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        empty, full, overflow, underflow;
  logic [3:0]  level;

  always #5 clk = ~clk;

  pio_fifo #(.WIDTH(32), .MAX_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .join_en  (join_en),
    .push     (push),
    .din      (din),
    .pull     (pull),
    .pull_en  (pull_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .underflow(underflow),
    .flag_clr (flag_clr)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  logic        m_join = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic        chk_en = 1'b0;
  logic [3:0]  exp_level;
  logic        exp_empty, exp_full, exp_ovf, exp_unf, blk;
  logic [31:0] exp_dout;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, snapshots the model's view of the current state,
  // advances the model by that cycle, then returns 2 time units after the edge.
  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic pl, input logic pe,
                               input logic c, input logic fc, input logic j, input logic r);
    int   sz, dep;
    logic rdm, wrm;
    push = p; din = d; pull = pl; pull_en = pe;
    clear = c; flag_clr = fc; join_en = j; reset = r;
    sz  = m_q.size();
    dep = m_join ? FIFO_DEPTH_JOINED : FIFO_DEPTH_SPLIT;
    exp_level = 4'(sz);
    exp_empty = (sz == 0);
    exp_full  = (sz == dep);
    exp_dout  = (sz > 0) ? m_q[0] : 32'h0;
    exp_ovf   = m_ovf;
    exp_unf   = m_unf;
    blk       = r | c | (j != m_join);
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rdm = pl && pe && (sz > 0);
      wrm = p && ((sz < dep) || rdm);
      if (c || (j != m_join)) m_q.delete();
      else begin
        if (rdm) exp_q.push_back(m_q.pop_front());
        if (wrm) m_q.push_back(d);
      end
      if (fc) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (p && !wrm)            m_ovf = 1'b1;
        if (pl && pe && (sz == 0)) m_unf = 1'b1;
      end
    end
    m_join = j;
    @(posedge clk);
    #2;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_level"}, 32'(level), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_dout"}, dout, 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  task automatic randomPhase(input int n, input int push_pct, input int pull_pct);
    logic j;
    for (int i = 0; i < n; i++) begin
      j = m_join;
      if ($urandom_range(39) == 0) j = ~j;
      applyStimulus($urandom_range(99) < push_pct, $urandom, $urandom_range(99) < pull_pct,
                    $urandom_range(3) != 0, $urandom_range(29) == 0, $urandom_range(14) == 0,
                    j, $urandom_range(99) == 0);
    end
  endtask

  // Monitor: status against the model every cycle, data popped on each accepted read.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("level", 32'(level), 32'(exp_level));
      checkOutput("empty", 32'(empty), 32'(exp_empty));
      checkOutput("full", 32'(full), 32'(exp_full));
      checkOutput("dout", dout, exp_dout);
      checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
      checkOutput("underflow", 32'(underflow), 32'(exp_unf));
      if (pull && pull_en && !empty && !blk) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL pop_unexpected: DUT read dout 0x%0h, expected no accepted read", dout);
        end else begin
          checkOutput("pop_data", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; join_en = 1'b0; push = 1'b0; pull = 1'b0;
    pull_en = 1'b0; flag_clr = 1'b0; din = '0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    checkReset("rst");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Split mode: four writes fill it, the fifth is dropped.
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'(32'h11 * (k + 1)), 0, 0, 0, 0, 0, 0);
    checkOutput("split_full", 32'(full), 32'd1);
    checkOutput("split_level", 32'(level), 32'd4);
    applyStimulus(1, 32'h55, 0, 0, 0, 0, 0, 0);
    checkOutput("split_ovf", 32'(overflow), 32'd1);
    checkOutput("split_level_ovf", 32'(level), 32'd4);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("split_drained", 32'(empty), 32'd1);

    // Joined mode: full only after the eighth write.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 32'(k), 0, 0, 0, 0, 1, 0);
      if (k == 6) checkOutput("join_not_full7", 32'(full), 32'd0);
    end
    checkOutput("join_full8", 32'(full), 32'd1);
    checkOutput("join_level8", 32'(level), 32'd8);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, 1, 0, 0, 1, 0);
    checkOutput("join_empty", 32'(empty), 32'd1);
    checkOutput("join_dout0", dout, 32'd0);

    // Full with simultaneous push and read.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'(32'hA0 + k), 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'hAA, 1, 1, 0, 0, 0, 0);
    checkOutput("full_rw_level", 32'(level), 32'd4);
    checkOutput("full_rw_ovf", 32'(overflow), 32'd0);
    checkOutput("full_rw_head", dout, 32'hA1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);

    // Unqualified pulls are never flagged; a qualified one is.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("unf_unqualified", 32'(underflow), 32'd0);
    end
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("unf_qualified", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("unf_cleared", 32'(underflow), 32'd0);

    // Empty with simultaneous push and pull.
    applyStimulus(1, 32'h5A, 1, 1, 0, 0, 0, 0);
    checkOutput("empty_rw_level", 32'(level), 32'd1);
    checkOutput("empty_rw_unf", 32'(underflow), 32'd1);
    checkOutput("empty_rw_dout", dout, 32'h5A);
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 0);

    // Join toggle flushes; reset mid-burst discards everything.
    for (int k = 0; k < 3; k++) applyStimulus(1, 32'(32'hC0 + k), 0, 0, 0, 0, 0, 0);
    checkOutput("toggle_pre_level", 32'(level), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("toggle_level", 32'(level), 32'd0);
    checkOutput("toggle_empty", 32'(empty), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(1, 32'(32'hD0 + k), 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'hDD, 1, 1, 0, 0, 1, 1);
    checkReset("midrst");
    applyStimulus(1, 32'h77, 0, 0, 0, 0, 1, 0);
    checkOutput("post_rst_head", dout, 32'h77);
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 0);

    randomPhase(400, 70, 40);
    randomPhase(300, 30, 80);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 1, 1, 0, 0, m_join, 0);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_fifo.md
PIO_FIFO -- requirements
Module: pio_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter MAX_DEPTH, default 8, physical storage entries (power of two).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port clear  input  1  synchronous flush: contents discarded, sticky flags kept.
REQ-006 Port join  input  1  0: usable depth MAX_DEPTH/2; 1: usable depth MAX_DEPTH.
REQ-007 Port push  input  1  write request from producer (system side or state-machine push).
REQ-008 Port din  input  WIDTH  write data, sampled when a write is accepted.
REQ-009 Port pull  input  1  read request, combinational from the consuming state machine.
REQ-010 Port pull_en  input  1  read qualifier (state-machine en & penable); pull ignored when 0.
REQ-011 Port dout  output  WIDTH  head-of-queue word, first-word-fall-through.
REQ-012 Port empty  output  1  level == 0.
REQ-013 Port full  output  1  level == current usable depth.
REQ-014 Port level  output  4  number of stored words, 0..MAX_DEPTH.
REQ-015 Port overflow  output  1  sticky: write refused because full.
REQ-016 Port underflow  output  1  sticky: qualified read attempted while empty.
REQ-017 Port flag_clr  input  1  clears overflow and underflow.

Function
REQ-018 Write accepted (wr) = push & (!full | rd), where rd is defined in REQ-019; on wr, din is stored at the write pointer and the pointer advances.
REQ-019 Read accepted (rd) = pull & pull_en & !empty; on rd, the read pointer advances.
REQ-020 Pointers are log2(MAX_DEPTH) bits wide and wrap at the usable depth: modulo 4 when join=0, modulo 8 when join=1 (MAX_DEPTH=8).
REQ-021 level increments on wr only, decrements on rd only, and is unchanged when wr and rd occur in the same cycle.
REQ-022 Full plus simultaneous push and rd: both accepted; level stays at depth; the new word lands in the slot just freed.
REQ-023 Empty plus simultaneous push and pull: write accepted; read refused; underflow set; level becomes 1; dout shows din from the next cycle.
REQ-024 dout = storage[read pointer] when !empty, else all zeros; zero read latency; dout is valid in the cycle after the accepting write.
REQ-025 push while full without rd: word dropped; storage, pointers and level unchanged; overflow set.
REQ-026 pull & pull_en while empty: no state change except underflow set. pull with pull_en=0 has no effect and is never flagged.
REQ-027 Any change of join between consecutive cycles performs an implicit clear in the cycle after the change.
REQ-028 clear has priority over wr and rd in the same cycle: pointers and level go to 0; storage need not be zeroed.
REQ-029 flag_clr has priority over a same-cycle flag set; flags are otherwise set-only.
REQ-030 empty, full and level are registered-state derived, with no combinational path from push or pull to these outputs.

Reset
REQ-031 On reset: pointers 0, level 0, empty 1, full 0, dout 0, overflow 0, underflow 0.
REQ-032 reset overrides clear, flag_clr, push and pull in the same cycle.
REQ-033 Reset asserted mid-stream discards all words; the first write after deassertion is the first word read.

Structure
REQ-034 Shared package pio_pkg holds FIFO_DEPTH_JOINED=8, FIFO_DEPTH_SPLIT=4 and LEVEL_W=4, and is shared with the state-machine wrapper.
REQ-035 Storage is a separate sub-module pio_fifo_mem: MAX_DEPTH x WIDTH, synchronous write, asynchronous read. Pointer, level and flag logic stay in pio_fifo.

Verification
REQ-036 join=0: push 0x11,0x22,0x33,0x44, then push 0x55 -> full=1 after the 4th write, 0x55 dropped, overflow=1, level=4; subsequent reads return 0x11..0x44 in order.
REQ-037 join=1: eight writes 0..7 -> full only after the 8th; pointers wrap correctly; reads return 0..7, then empty=1 and dout=0.
REQ-038 level=4 (full, join=0), push 0xAA with pull & pull_en in the same cycle -> head popped, 0xAA stored, level stays 4, no overflow.
REQ-039 Empty, pull=1 with pull_en=0 for 3 cycles, then pull_en=1 for 1 cycle -> underflow set only on the qualified cycle; flag_clr clears it.
REQ-040 level=3, toggle join -> level=0 and empty=1 in the next cycle; reset asserted during a push burst -> all outputs at reset values in the next cycle.
